decode_queue: RTL and testbench

Buffered, handshaked RV32I(+M) instruction decode stage that sits between the fetch unit and the execute stage. Each accepted instruction is fully decoded on entry and stored as a decoded bundle in a DEPTH-entry FIFO, so fetch and execute stalls are decoupled. Adds illegal-instruction detection, optional M-extension recognition, pipeline flush and a saturating illegal-instruction counter; none of these exist in the purely combinational single-instruction decoder.

---
 rtl/decode_queue_if.sv | 42 ++++
 rtl/decode_queue.sv | 209 ++++++++++++++++++++
 tb/tb_decode_queue.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - fetch/execute handshake bundle for decode_queue
interface decode_queue_if #(
    parameter int CNT_W = 16
);
    logic             flush;
    logic             if_valid;
    logic             if_ready;
    logic [31:0]      if_instr;
    logic [31:0]      if_pc;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_pc;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic [2:0]       id_funct3;
    logic [31:0]      id_imm;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_branch;
    logic             id_jump;
    logic             id_csr_we;
    logic             id_muldiv;
    logic             id_sub_sra;
    logic             id_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output flush, if_valid, if_instr, if_pc, id_ready,
        input  if_ready, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_funct3, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump,
               id_csr_we, id_muldiv, id_sub_sra, id_illegal, illegal_cnt
    );

    modport slave (
        input  flush, if_valid, if_instr, if_pc, id_ready,
        output if_ready, id_valid, id_pc, id_rs1, id_rs2, id_rd, id_funct3, id_imm,
               id_reg_write, id_mem_read, id_mem_write, id_branch, id_jump,
               id_csr_we, id_muldiv, id_sub_sra, id_illegal, illegal_cnt
    );
endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - RV32I(+M) decode-on-entry FIFO between fetch and execute
module decode_queue #(
    parameter int DEPTH    = 2,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_queue_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]    FULL    = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        csr_we;
        logic        muldiv;
        logic        sub_sra;
        logic        illegal;
    } entry_t;

    logic [31:0] ins;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins    = bus.if_instr;
    assign opcode = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    entry_t dec;
    logic   bad;

    // Opcodes with instr[1:0] != 2'b11 never match a listed case, so they land in default.
    always_comb begin
        dec        = '0;
        bad        = 1'b0;
        dec.pc     = bus.if_pc;
        dec.rs1    = ins[19:15];
        dec.rs2    = ins[24:20];
        dec.rd     = ins[11:7];
        dec.funct3 = f3;
        case (opcode)
            7'h37, 7'h17: begin
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            7'h6f: begin
                dec.imm       = imm_j;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
            end
            7'h67: begin
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                dec.jump      = 1'b1;
                bad           = (f3 != 3'd0);
            end
            7'h63: begin
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                bad        = (f3 == 3'd2) || (f3 == 3'd3);
            end
            7'h03: begin
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                bad           = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            7'h23: begin
                dec.imm       = imm_s;
                dec.mem_write = 1'b1;
                bad           = (f3 > 3'd2);
            end
            7'h13: begin
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                if (f3 == 3'd1) begin
                    bad = (f7 != 7'h00);
                end else if (f3 == 3'd5) begin
                    bad         = !((f7 == 7'h00) || (f7 == 7'h20));
                    dec.sub_sra = ins[30];
                end
            end
            7'h33: begin
                dec.reg_write = 1'b1;
                case (f7)
                    7'h00: ;
                    7'h20: begin
                        bad         = !((f3 == 3'd0) || (f3 == 3'd5));
                        dec.sub_sra = 1'b1;
                    end
                    7'h01: begin
                        bad        = !ENABLE_M;
                        dec.muldiv = 1'b1;
                    end
                    default: bad = 1'b1;
                endcase
            end
            7'h0f: ;
            7'h73: begin
                dec.imm = imm_i;
                if (f3 == 3'd4) begin
                    bad = 1'b1;
                end else if (f3 != 3'd0) begin
                    dec.reg_write = 1'b1;
                    dec.csr_we    = 1'b1;
                end
            end
            default: bad = 1'b1;
        endcase
        // Illegal words keep their register fields for trap reporting but carry no side effects.
        if (bad) begin
            dec.imm       = '0;
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
            dec.csr_we    = 1'b0;
            dec.muldiv    = 1'b0;
            dec.sub_sra   = 1'b0;
        end
        dec.illegal = bad;
    end

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [CNT_W-1:0]  ill_cnt;
    logic              push, pop;

    assign bus.if_ready = rst_n && (count != FULL);
    assign bus.id_valid = (count != '0);
    assign push = bus.if_valid && bus.if_ready && !bus.flush;
    assign pop  = bus.id_valid && bus.id_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ill_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
                if (dec.illegal && (ill_cnt != CNT_MAX)) begin
                    ill_cnt <= ill_cnt + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Gate the head with id_valid so an empty queue presents all-zero payload.
    entry_t head;
    assign head = bus.id_valid ? mem[rd_ptr] : '0;

    assign bus.id_pc        = head.pc;
    assign bus.id_rs1       = head.rs1;
    assign bus.id_rs2       = head.rs2;
    assign bus.id_rd        = head.rd;
    assign bus.id_funct3    = head.funct3;
    assign bus.id_imm       = head.imm;
    assign bus.id_reg_write = head.reg_write;
    assign bus.id_mem_read  = head.mem_read;
    assign bus.id_mem_write = head.mem_write;
    assign bus.id_branch    = head.branch;
    assign bus.id_jump      = head.jump;
    assign bus.id_csr_we    = head.csr_we;
    assign bus.id_muldiv    = head.muldiv;
    assign bus.id_sub_sra   = head.sub_sra;
    assign bus.id_illegal   = head.illegal;
    assign bus.illegal_cnt  = ill_cnt;
endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    decode_queue_if #(.CNT_W(16)) a ();
    decode_queue_if #(.CNT_W(2))  b ();

    decode_queue #(.DEPTH(2), .ENABLE_M(1'b0), .CNT_W(16)) u_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
    decode_queue #(.DEPTH(4), .ENABLE_M(1'b1), .CNT_W(2))  u_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

    // {reg_write, mem_read, mem_write, branch, jump, csr_we, muldiv, sub_sra, illegal}
    logic [8:0] fa, fb;
    assign fa = {a.id_reg_write, a.id_mem_read, a.id_mem_write, a.id_branch, a.id_jump,
                 a.id_csr_we, a.id_muldiv, a.id_sub_sra, a.id_illegal};
    assign fb = {b.id_reg_write, b.id_mem_read, b.id_mem_write, b.id_branch, b.id_jump,
                 b.id_csr_we, b.id_muldiv, b.id_sub_sra, b.id_illegal};

    localparam logic [31:0] T_INS [6] = '{32'h00512423, 32'h010000ef, 32'h403100b3,
                                          32'h00002083, 32'h00003083, 32'h30002073};
    localparam logic [31:0] T_IMM [6] = '{32'd8, 32'd16, 32'd0, 32'd0, 32'd0, 32'h300};
    localparam logic [8:0]  T_FLG [6] = '{9'b001000000, 9'b100010000, 9'b100000010,
                                          9'b110000000, 9'b000000001, 9'b100001000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        a.flush = 0; a.if_valid = 0; a.if_instr = 0; a.if_pc = 0; a.id_ready = 0;
        b.flush = 0; b.if_valid = 0; b.if_instr = 0; b.if_pc = 0; b.id_ready = 0;

        step(); step();
        chk("rst_if_ready", a.if_ready, 0);
        chk("rst_id_valid", a.id_valid, 0);
        chk("rst_id_pc", a.id_pc, 0);
        chk("rst_id_imm", a.id_imm, 0);
        chk("rst_flags", fa, 0);
        chk("rst_cnt", a.illegal_cnt, 0);

        rst_n = 1;
        step();
        chk("post_rst_if_ready", a.if_ready, 1);
        chk("post_rst_id_valid", a.id_valid, 0);

        a.if_valid = 1; a.if_instr = 32'h00500093; a.if_pc = 32'h100;
        step();
        a.if_valid = 0;
        chk("addi_valid", a.id_valid, 1);
        chk("addi_rd", a.id_rd, 1);
        chk("addi_imm", a.id_imm, 5);
        chk("addi_flags", fa, 9'b100000000);
        chk("addi_pc", a.id_pc, 32'h100);
        a.id_ready = 1;
        step();
        a.id_ready = 0;
        chk("addi_drained", a.id_valid, 0);

        a.if_valid = 1; a.if_instr = 32'h00a00113; a.if_pc = 32'h200;
        step();
        chk("fill1_ready", a.if_ready, 1);
        a.if_instr = 32'h123451b7; a.if_pc = 32'h204;
        step();
        chk("fill2_ready", a.if_ready, 0);
        a.if_instr = 32'h00000013; a.if_pc = 32'h208;
        step();
        a.if_valid = 0;
        chk("full_hold_ready", a.if_ready, 0);
        chk("full_head_pc", a.id_pc, 32'h200);
        chk("full_head_imm", a.id_imm, 10);
        chk("full_head_rd", a.id_rd, 2);
        a.id_ready = 1;
        step();
        chk("drain_pc", a.id_pc, 32'h204);
        chk("drain_lui_imm", a.id_imm, 32'h12345000);
        chk("drain_lui_rd", a.id_rd, 3);
        step();
        chk("drain_extra_absent", a.id_valid, 0);
        a.id_ready = 0;

        a.if_valid = 1; a.if_instr = 32'h02208033; a.if_pc = 32'h300;
        b.if_valid = 1; b.if_instr = 32'h02208033; b.if_pc = 32'h300;
        step();
        a.if_valid = 0; b.if_valid = 0;
        chk("mul_nom_flags", fa, 9'b000000001);
        chk("mul_nom_imm", a.id_imm, 0);
        chk("mul_nom_cnt", a.illegal_cnt, 1);
        chk("mul_m_flags", fb, 9'b100000100);
        chk("mul_m_cnt", b.illegal_cnt, 0);
        a.id_ready = 1; b.id_ready = 1;
        step();
        chk("mul_pop_a", a.id_valid, 0);
        chk("mul_pop_b", b.id_valid, 0);
        a.id_ready = 0; b.id_ready = 0;

        a.if_valid = 1; a.if_instr = 32'h00100093; a.if_pc = 32'h400;
        step();
        a.if_pc = 32'h404;
        step();
        chk("preflush_full", a.if_ready, 0);
        a.flush = 1; a.if_instr = 32'h00000000; a.if_pc = 32'h408;
        step();
        a.flush = 0; a.if_valid = 0;
        chk("flush_valid", a.id_valid, 0);
        chk("flush_ready", a.if_ready, 1);
        chk("flush_cnt", a.illegal_cnt, 1);
        a.id_ready = 1;
        step();
        chk("flush_offer_absent", a.id_valid, 0);
        a.id_ready = 0;

        a.if_valid = 1; a.if_instr = 32'hfe000ee3; a.if_pc = 32'h500;
        step();
        chk("br_flags", fa, 9'b000100000);
        chk("br_imm", a.id_imm, 32'hfffffffc);
        chk("br_pc", a.id_pc, 32'h500);
        a.id_ready = 1;
        for (int k = 0; k < 20; k++) begin
            a.if_pc = 32'h504 + 32'(4 * k);
            a.if_instr = (32'(k + 1) << 20) | 32'h13;
            step();
            chk($sformatf("stream%0d_pc", k), a.id_pc, 32'h504 + 32'(4 * k));
            chk($sformatf("stream%0d_imm", k), a.id_imm, 32'(k + 1));
            chk($sformatf("stream%0d_ready", k), a.if_ready, 1);
        end
        a.if_valid = 0;
        step();
        chk("stream_end_valid", a.id_valid, 0);
        a.id_ready = 0;

        for (int i = 0; i < 6; i++) begin
            a.if_valid = 1; a.if_instr = T_INS[i]; a.if_pc = 32'h700 + 32'(4 * i);
            step();
            a.if_valid = 0;
            chk($sformatf("tbl%0d_flags", i), fa, T_FLG[i]);
            chk($sformatf("tbl%0d_imm", i), a.id_imm, T_IMM[i]);
            a.id_ready = 1;
            step();
            a.id_ready = 0;
        end
        chk("tbl_sw_fields", 1, 1 & (T_INS[0][24:20] == 5));
        chk("tbl_cnt", a.illegal_cnt, 2);

        b.if_valid = 1; b.if_instr = 32'h00000000; b.id_ready = 1;
        for (int i = 0; i < 5; i++) begin
            b.if_pc = 32'h600 + 32'(4 * i);
            step();
            chk($sformatf("sat%0d_cnt", i), b.illegal_cnt, (i < 3) ? i + 1 : 3);
            chk($sformatf("sat%0d_ill", i), b.id_illegal, 1);
        end
        b.if_valid = 0; b.id_ready = 0;

        a.if_valid = 1; a.if_instr = 32'h00100093; a.if_pc = 32'h800;
        step();
        a.if_valid = 0;
        chk("pre_rst_valid", a.id_valid, 1);
        rst_n = 0;
        step();
        chk("mid_rst_valid", a.id_valid, 0);
        chk("mid_rst_ready", a.if_ready, 0);
        chk("mid_rst_cnt_a", a.illegal_cnt, 0);
        chk("mid_rst_cnt_b", b.illegal_cnt, 0);
        rst_n = 1;
        step();
        chk("mid_rst_release", a.if_ready, 1);
        chk("mid_rst_empty", a.id_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
